hazard_ctrl: RTL and testbench

//  Stall/flush controller for the 5-stage pipeline; drives the ID/EX register's id_ex_ctrl bubble input and the

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Bundle of the hazard controller's pipeline-side inputs and control outputs.
// The slave modport is the controller; the master modport is the pipeline driving it.
interface hazard_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs_id;
   logic [4:0]       Rt_id;
   logic             uses_rt_id;
   logic [4:0]       Rt_ex;
   logic             MemtoReg_ex;
   logic             RegWr_ex;
   logic             branch_taken;
   logic             dmem_req;
   logic             dmem_ack;
   logic             pc_hold;
   logic             if_id_hold;
   logic             if_id_flush;
   logic             id_ex_ctrl;
   logic             id_ex_hold;
   logic             ex_mem_hold;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;

   modport slave (
      input  Rs_id, Rt_id, uses_rt_id, Rt_ex, MemtoReg_ex, RegWr_ex,
             branch_taken, dmem_req, dmem_ack,
      output pc_hold, if_id_hold, if_id_flush, id_ex_ctrl, id_ex_hold,
             ex_mem_hold, mem_err, stall_cycles
   );

   modport master (
      output Rs_id, Rt_id, uses_rt_id, Rt_ex, MemtoReg_ex, RegWr_ex,
             branch_taken, dmem_req, dmem_ack,
      input  pc_hold, if_id_hold, if_id_flush, id_ex_ctrl, id_ex_hold,
             ex_mem_hold, mem_err, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait states, with a sticky timeout error and a stall counter.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   hazard_if.slave  hif
);
   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [WCNT_W-1:0] wait_cnt_r;
   logic [WCNT_W-1:0] wait_cnt_s;
   logic [WCNT_W-1:0] wait_inc_s;
   logic              timeout_s;
   logic              err_set_s;
   logic              mem_stall_s;
   logic              load_use_s;
   logic              mem_err_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic [5:0]        ctrl_s;
   logic [5:0]        ctrl_r;

   // Hazard detection and wait-counter arithmetic.
   always_comb begin
      load_use_s  = hif.MemtoReg_ex & hif.RegWr_ex & (hif.Rt_ex != 5'd0) &
                    ((hif.Rt_ex == hif.Rs_id) | (hif.uses_rt_id & (hif.Rt_ex == hif.Rt_id)));
      mem_stall_s = hif.dmem_req & ~hif.dmem_ack & ~mem_err_r;
      wait_inc_s  = wait_cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
      timeout_s   = (wait_inc_s >= WCNT_W'(MEM_TIMEOUT));
   end

   // Next-state logic in priority order: memory wait, branch flush, load-use, run.
   always_comb begin
      state_s    = RUN;
      wait_cnt_s = '0;
      err_set_s  = 1'b0;
      if (mem_stall_s) begin
         if (state_r == MEM_WAIT) begin
            if (timeout_s) begin
               state_s   = RUN;
               err_set_s = 1'b1;
            end else begin
               state_s    = MEM_WAIT;
               wait_cnt_s = wait_inc_s;
            end
         end else begin
            state_s = MEM_WAIT;
         end
      end else if (state_r == MEM_WAIT) begin
         state_s = RUN;
      end else if (hif.branch_taken) begin
         state_s = FLUSH;
      end else if (load_use_s && (state_r == RUN)) begin
         state_s = LU_STALL;
      end else begin
         state_s = RUN;
      end
   end

   // Output decode of the next state; bit order {pc, if_id_hold, if_id_flush, id_ex_ctrl, id_ex_hold, ex_mem_hold}.
   always_comb begin
      ctrl_s = 6'b000000;
      case (state_s)
         RUN:      ctrl_s = 6'b000000;
         LU_STALL: ctrl_s = 6'b110100;
         FLUSH:    ctrl_s = 6'b001100;
         MEM_WAIT: ctrl_s = 6'b110011;
         default:  ctrl_s = 6'b000000;
      endcase
   end

   // State, wait counter, registered controls, sticky error and saturating stall counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= RUN;
         wait_cnt_r  <= '0;
         ctrl_r      <= 6'b000000;
         mem_err_r   <= 1'b0;
         stall_cnt_r <= '0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         ctrl_r     <= ctrl_s;
         mem_err_r  <= mem_err_r | err_set_s;
         if (ctrl_r[5] && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign hif.pc_hold      = ctrl_r[5];
   assign hif.if_id_hold   = ctrl_r[4];
   assign hif.if_id_flush  = ctrl_r[3];
   assign hif.id_ex_ctrl   = ctrl_r[2];
   assign hif.id_ex_hold   = ctrl_r[1];
   assign hif.ex_mem_hold  = ctrl_r[0];
   assign hif.mem_err      = mem_err_r;
   assign hif.stall_cycles = stall_cnt_r;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus hand sequences for memory waits,
// timeout, counter saturation (narrow counter) and reset in the middle of a wait.
module tb_hazard_ctrl;
   localparam int CW = 4;
   localparam logic [5:0] NO = 6'b000000;
   localparam logic [5:0] LU = 6'b110100;
   localparam logic [5:0] FL = 6'b001100;
   localparam logic [5:0] MW = 6'b110011;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses;
      logic [4:0] rt_ex;
      logic       m;
      logic       w;
      logic       br;
      logic       req;
      logic       ack;
      logic [5:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t tbl[19];

   hazard_if #(.CNT_W(CW)) hif ();

   hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hif   (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      hif.Rs_id        = v.rs;
      hif.Rt_id        = v.rt;
      hif.uses_rt_id   = v.uses;
      hif.Rt_ex        = v.rt_ex;
      hif.MemtoReg_ex  = v.m;
      hif.RegWr_ex     = v.w;
      hif.branch_taken = v.br;
      hif.dmem_req     = v.req;
      hif.dmem_ack     = v.ack;
   endtask

   task automatic tick_check(input string nm, input logic [5:0] exp, input logic exp_err);
      logic [5:0] act;
      @(posedge clk);
      #1;
      act = {hif.pc_hold, hif.if_id_hold, hif.if_id_flush,
             hif.id_ex_ctrl, hif.id_ex_hold, hif.ex_mem_hold};
      chk(nm, int'(act), int'(exp));
      chk({nm, "_err"}, int'(hif.mem_err), int'(exp_err));
   endtask

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic [4:0] rt_ex, input logic m, input logic w,
                               input logic br, input logic req, input logic ack,
                               input logic [5:0] exp);
      vec_t v;
      v.rs = rs; v.rt = rt; v.uses = uses; v.rt_ex = rt_ex; v.m = m; v.w = w;
      v.br = br; v.req = req; v.ack = ack; v.exp = exp;
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NO));
      tick_check("reset", NO, 1'b0);
      chk("reset_stall", int'(hif.stall_cycles), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t idle;
      total = 0;
      bad   = 0;
      idle  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NO);

      tbl[0]  = idle;
      tbl[1]  = mk(5'd2, 5'd7, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU);
      tbl[2]  = idle;
      tbl[3]  = mk(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NO);
      tbl[4]  = mk(5'd5, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NO);
      tbl[5]  = mk(5'd5, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU);
      tbl[6]  = idle;
      tbl[7]  = mk(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NO);
      tbl[8]  = mk(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FL);
      tbl[9]  = idle;
      tbl[10] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FL);
      tbl[11] = mk(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NO);
      tbl[12] = mk(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU);
      tbl[13] = mk(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NO);
      tbl[14] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MW);
      tbl[15] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NO);
      tbl[16] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, MW);
      tbl[17] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NO);
      tbl[18] = idle;

      do_reset();
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i]);
         tick_check($sformatf("vec%0d", i), tbl[i].exp, 1'b0);
      end
      chk("table_stall_cnt", int'(hif.stall_cycles), 5);

      // Wait acknowledged after three cycles.
      do_reset();
      drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NO));
      for (int k = 0; k < 3; k++) tick_check($sformatf("wait3_%0d", k), MW, 1'b0);
      hif.dmem_ack = 1'b1;
      tick_check("wait3_exit", NO, 1'b0);
      drive(idle);
      tick_check("wait3_idle", NO, 1'b0);
      chk("wait3_stall_cnt", int'(hif.stall_cycles), 3);

      // Wait never acknowledged: 16 wait cycles, then sticky error; counter saturates at 15.
      do_reset();
      drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NO));
      for (int k = 0; k < 16; k++) tick_check($sformatf("tmo_%0d", k), MW, 1'b0);
      tick_check("tmo_exit", NO, 1'b1);
      tick_check("tmo_req_ignored", NO, 1'b1);
      chk("tmo_stall_sat", int'(hif.stall_cycles), 15);
      drive(mk(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, NO));
      tick_check("sat_lu", LU, 1'b1);
      drive(idle);
      tick_check("sat_idle", NO, 1'b1);
      chk("sat_no_wrap", int'(hif.stall_cycles), 15);

      // Reset during the second wait cycle clears everything, including mem_err.
      drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NO));
      do_reset();
      hif.dmem_req = 1'b1;
      tick_check("rst_w1", MW, 1'b0);
      tick_check("rst_w2", MW, 1'b0);
      rst_n = 1'b0;
      tick_check("rst_mid", NO, 1'b0);
      chk("rst_mid_stall", int'(hif.stall_cycles), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) tick_check($sformatf("rst_rewait_%0d", k), MW, 1'b0);
      tick_check("rst_rewait_exit", NO, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
